// File: rtl/cpu_checker_logger_pkg.sv
// Shared definitions for the cpu_checker verdict logger: format codes, record
// field widths and counter slot indices.
package cpu_checker_logger_pkg;

  typedef enum logic [1:0] {
    FMT_NONE = 2'd0,
    FMT_REG  = 2'd1,
    FMT_MEM  = 2'd2,
    FMT_RSV  = 2'd3
  } fmt_e;

  localparam int unsigned FMT_W = 2;
  localparam int unsigned ERR_W = 4;

  // Record layout, MSB first: {seq, fmt, err}
  localparam int unsigned CI_TOTAL = 0;
  localparam int unsigned CI_REG   = 1;
  localparam int unsigned CI_MEM   = 2;
  localparam int unsigned CI_ERR   = 3;
  localparam int unsigned CI_DROP  = 4;
  localparam int unsigned N_CNT    = 5;

endpackage

// File: rtl/cpu_checker_logger_fifo.sv
// chk_log_fifo: generic DEPTH x W synchronous show-ahead FIFO. Pointers carry
// one extra wrap bit; a push into a full FIFO succeeds only alongside a pop.
module chk_log_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 22
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    dout     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is only observed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cpu_checker_logger.sv
// cpu_checker_logger: turns the cpu_checker verdict stream into sequenced records
// and saturating statistics. CHK_LOG_ERR_ONLY_EN: enqueue only error records.
module cpu_checker_logger
  import cpu_checker_logger_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEQ_W = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       format_type,
  input  logic [3:0]       error_code,
  input  logic             clr,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [SEQ_W-1:0] rd_seq,
  output logic [1:0]       rd_fmt,
  output logic [3:0]       rd_err,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_reg,
  output logic [CNT_W-1:0] cnt_mem,
  output logic [CNT_W-1:0] cnt_err,
  output logic [CNT_W-1:0] cnt_drop,
  output logic             overflow
);

  localparam int unsigned REC_W = SEQ_W + FMT_W + ERR_W;

  logic             clear;
  logic             evt, enq_req, push, pop, drop;
  logic             full, empty;
  logic [REC_W-1:0] rec_in, rec_head;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] cnt_q [N_CNT];
  logic [CNT_W-1:0] cnt_d [N_CNT];
  logic [N_CNT-1:0] inc;

  // clr acts through the same path as reset, so a same-cycle event is lost.
  assign clear = reset || clr;

  always_comb begin
    evt = (format_type != FMT_NONE);
`ifdef CHK_LOG_ERR_ONLY_EN
    enq_req = evt && (error_code != '0);
`else
    enq_req = evt;
`endif
    pop    = !empty && rd_ready;
    push   = enq_req && (!full || pop);
    drop   = enq_req && full && !pop;
    rec_in = {seq_q, format_type, error_code};

    inc           = '0;
    inc[CI_TOTAL] = evt;
    inc[CI_REG]   = (format_type == FMT_REG);
    inc[CI_MEM]   = (format_type == FMT_MEM);
    inc[CI_ERR]   = evt && (error_code != '0);
    inc[CI_DROP]  = drop;
    for (int unsigned i = 0; i < N_CNT; i++) begin
      cnt_d[i] = (inc[i] && (cnt_q[i] != '1)) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
    end

    seq_d      = evt ? seq_q + SEQ_W'(1) : seq_q;
    overflow_d = overflow_q || drop;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      seq_q      <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < N_CNT; i++) cnt_q[i] <= '0;
    end else begin
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      for (int unsigned i = 0; i < N_CNT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  chk_log_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (clear),
    .push  (push),
    .pop   (pop),
    .din   (rec_in),
    .full  (full),
    .empty (empty),
    .dout  (rec_head)
  );

  always_comb begin
    rd_valid                 = !empty;
    {rd_seq, rd_fmt, rd_err} = empty ? '0 : rec_head;
    cnt_total                = cnt_q[CI_TOTAL];
    cnt_reg                  = cnt_q[CI_REG];
    cnt_mem                  = cnt_q[CI_MEM];
    cnt_err                  = cnt_q[CI_ERR];
    cnt_drop                 = cnt_q[CI_DROP];
    overflow                 = overflow_q;
  end

endmodule
